tlb_seq: RTL and testbench
==========================

TLB_SEQ -- requirements
Module: tlb_seq

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, meaning number of TLB entries (power of 2); IDXBITS = log2(TLB_ENTRIES).
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  request valid.
- op_ready  out  1  request accepted when high with op_valid.
- op_type  in  2  operation: 0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR.
- cp0_index, cp0_random, cp0_entryhi, cp0_entrylo0, cp0_entrylo1  in  32 each  current CP0 values.
- cp0_mask  in  12  PageMask mask field.
- tlb_rd_idx  out  IDXBITS  TLB read index; synchronous read, data valid the next cycle.
- tlb_rd_hi, tlb_rd_lo0, tlb_rd_lo1  in  32 each  read entry.
- tlb_rd_mask  in  12  read entry mask.
- tlb_we  out  1  TLB write strobe.
- tlb_wr_idx  out  IDXBITS  write index.
- tlb_wr_hi, tlb_wr_lo0, tlb_wr_lo1  out  32 each  write data.
- tlb_wr_mask  out  12  write mask.
- tlbr  out  1  one-cycle pulse; CP0 loads tlbr_hi/lo0/lo1/mask.
- tlbr_hi, tlbr_lo0, tlbr_lo1  out  32 each  TLBR result.
- tlbr_mask  out  12  TLBR result mask.
- tlbp  out  1  one-cycle pulse; CP0 loads tlbp_index.
- tlbp_index  out  32  bit 31 = P (miss), low IDXBITS = hit index.
- tlbwr  out  1  one-cycle pulse after a TLBWR write; advances Random.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL use states IDLE, PROBE, READ, READ2, WRITE, RESP; op_ready = (state==IDLE).
REQ-004 On accept (cycle A), SHALL snapshot all cp0_* inputs and op_type; TLBP->PROBE, TLBR->READ, TLBWI/TLBWR->WRITE.
REQ-005 PROBE SHALL present scan index 0 at A+1, increment by one per cycle, and compare the entry returned for the previous index; entries 0..N-1 compared at A+2..A+N+1.
REQ-006 Match SHALL be: (hi[31:13] ^ snap_hi[31:13]) & ~{7'b0,tlb_rd_mask} == 0, AND ((lo0[0] & lo1[0]) OR hi[7:0]==snap_hi[7:0]).
REQ-007 SHALL report the lowest matching index; scan counter SHALL NOT wrap.
REQ-008 PROBE->RESP after the last compare, giving tlbp at A+N+2; tlbp_index = {1'b0,...,idx} on hit, 32'h8000_0000 on miss.
REQ-009 TLBR: READ at A+1 SHALL present snap_index[IDXBITS-1:0]; READ2 at A+2 SHALL register tlb_rd_*; RESP at A+3 SHALL pulse tlbr with the registered data.
REQ-010 TLBWI/TLBWR: WRITE at A+1 SHALL assert tlb_we for exactly one cycle, tlb_wr_idx = snap_index (TLBWI) or snap_random (TLBWR) low IDXBITS bits, data = snapshots; RESP at A+2.
REQ-011 RESP SHALL last one cycle, pulse done (plus tlbp/tlbr/tlbwr per op), then return to IDLE; next accept no earlier than RESP+1.
REQ-012 cp0_* changes after accept SHALL NOT affect the operation in progress.
REQ-013 All outputs except op_ready SHALL be registered; tlbr_*/tlbp_index SHALL hold their values until the next RESP.

Reset
REQ-014 Reset SHALL asynchronously force IDLE, scan counter 0, tlb_we/tlbr/tlbp/tlbwr/done 0, tlb_rd_idx 0, tlbp_index 0, tlbr_* 0, tlb_wr_* 0; op_ready = 1.
REQ-015 Reset during any state SHALL abort the operation with no write, pulse, or done.

Configuration
REQ-016 With TLBSEQ_EARLY_EXIT_EN defined, PROBE SHALL go to RESP the cycle after the first match (hit at k: tlbp at A+k+3); misses still take A+N+2.
REQ-017 Without TLBSEQ_EARLY_EXIT_EN, PROBE SHALL always scan all entries (REQ-008).

Verification
REQ-018 TLBR, snap_index=5, entry5 hi=0x0040_2011, lo0=0x0000_1017, lo1=0x0000_1057, mask=0 -> tlbr=1 at A+3 with those values; done same cycle.
REQ-019 TLBP, entryhi=0x0040_2011, entries 3 and 9 match -> tlbp_index=3; tlbp at A+6 (EARLY_EXIT) or A+18 (full scan).
REQ-020 TLBP, no match -> tlbp_index=0x8000_0000 at A+18 in both builds.
REQ-021 Entry 4 ASID 0x22, probe ASID 0x11 -> hit when lo0[0]=lo1[0]=1, miss when only lo0[0]=1; mask=0xFFF hit ignores VPN2 bits 24:13.
REQ-022 TLBWR, random=9 -> tlb_we=1 only at A+1 with tlb_wr_idx=9; tlbwr=1 and done=1 only at A+2.
REQ-023 Reset at scan index 7 of TLBP -> IDLE immediately, op_ready=1, no tlbp/done.

Source files
------------

// File: rtl/tlb_seq.sv
// tlb_seq: sequencer for the CP0 TLB maintenance instructions TLBP, TLBR, TLBWI and TLBWR.
//
// One operation is accepted at a time. All cp0_* inputs and op_type are captured on accept, so
// later CP0 updates cannot disturb an operation in flight.
//   TLBP : scans every entry through the synchronous read port and reports the lowest hit.
//   TLBR : reads the entry at Index and returns it for CP0 to load.
//   TLBWI/TLBWR : writes the captured EntryHi/Lo0/Lo1/PageMask at Index or Random.
// Each operation ends with a one-cycle RESP state that pulses done (plus tlbp/tlbr/tlbwr).
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   op_valid/op_ready/op_type  request handshake; op_type 0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR
//   cp0_*                      current CP0 Index/Random/EntryHi/EntryLo0/EntryLo1/PageMask
//   tlb_rd_idx, tlb_rd_*       TLB read port (data valid the cycle after the index)
//   tlb_we, tlb_wr_*           TLB write port
//   tlbr, tlbr_*               TLBR result strobe and data (data held until the next TLBR)
//   tlbp, tlbp_index           TLBP result strobe and Index value (held until the next TLBP)
//   tlbwr                      pulses after a TLBWR write so CP0 can advance Random
//   done                       one-cycle completion pulse
//
// Build option
//   TLBSEQ_EARLY_EXIT_EN : when defined, TLBP leaves the scan right after the first hit.
//   When undefined, TLBP always compares all entries (fixed latency).
module tlb_seq #(
  parameter int unsigned TLB_ENTRIES = 16,
  localparam int unsigned IDXBITS = $clog2(TLB_ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         op_type,

  input  logic [31:0]        cp0_index,
  input  logic [31:0]        cp0_random,
  input  logic [31:0]        cp0_entryhi,
  input  logic [31:0]        cp0_entrylo0,
  input  logic [31:0]        cp0_entrylo1,
  input  logic [11:0]        cp0_mask,

  output logic [IDXBITS-1:0] tlb_rd_idx,
  input  logic [31:0]        tlb_rd_hi,
  input  logic [31:0]        tlb_rd_lo0,
  input  logic [31:0]        tlb_rd_lo1,
  input  logic [11:0]        tlb_rd_mask,

  output logic               tlb_we,
  output logic [IDXBITS-1:0] tlb_wr_idx,
  output logic [31:0]        tlb_wr_hi,
  output logic [31:0]        tlb_wr_lo0,
  output logic [31:0]        tlb_wr_lo1,
  output logic [11:0]        tlb_wr_mask,

  output logic               tlbr,
  output logic [31:0]        tlbr_hi,
  output logic [31:0]        tlbr_lo0,
  output logic [31:0]        tlbr_lo1,
  output logic [11:0]        tlbr_mask,

  output logic               tlbp,
  output logic [31:0]        tlbp_index,

  output logic               tlbwr,
  output logic               done
);

  localparam logic [IDXBITS-1:0] LAST_IDX = IDXBITS'(TLB_ENTRIES - 1);

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;
  localparam logic [1:0] OP_TLBWR = 2'd3;

  localparam logic [31:0] PROBE_MISS = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StProbe,
    StRead,
    StRead2,
    StWrite,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Captured request
  logic [1:0]         snap_op_q, snap_op_d;
  logic [31:0]        snap_hi_q, snap_hi_d;

  // Probe scan: rd_idx_q is the index being presented, cmp_idx_q the entry whose data is
  // on tlb_rd_* this cycle (one behind because of the synchronous read).
  logic [IDXBITS-1:0] rd_idx_q, rd_idx_d;
  logic [IDXBITS-1:0] cmp_idx_q, cmp_idx_d;
  logic               cmp_en_q, cmp_en_d;
  logic               hit_q, hit_d;
  logic [IDXBITS-1:0] hit_idx_q, hit_idx_d;

  // Write port
  logic               we_q, we_d;
  logic [IDXBITS-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]        wr_hi_q, wr_hi_d;
  logic [31:0]        wr_lo0_q, wr_lo0_d;
  logic [31:0]        wr_lo1_q, wr_lo1_d;
  logic [11:0]        wr_mask_q, wr_mask_d;

  // Results and strobes
  logic               tlbr_q, tlbr_d;
  logic [31:0]        tlbr_hi_q, tlbr_hi_d;
  logic [31:0]        tlbr_lo0_q, tlbr_lo0_d;
  logic [31:0]        tlbr_lo1_q, tlbr_lo1_d;
  logic [11:0]        tlbr_mask_q, tlbr_mask_d;
  logic               tlbp_q, tlbp_d;
  logic [31:0]        tlbp_index_q, tlbp_index_d;
  logic               tlbwr_q, tlbwr_d;
  logic               done_q, done_d;

  // Probe compare on the entry currently returned by the read port
  logic               vpn_match;
  logic               asid_match;
  logic               match;
  logic               probe_last;
  logic               probe_exit;
  logic               probe_hit;
  logic [IDXBITS-1:0] probe_idx;

  // PageMask bits widen the page, so masked VPN2 bits are don't-care.
  assign vpn_match  = ((tlb_rd_hi[31:13] ^ snap_hi_q[31:13]) & ~{7'b0, tlb_rd_mask}) == 19'd0;
  // Global entries (G set in both halves) match any ASID.
  assign asid_match = (tlb_rd_lo0[0] & tlb_rd_lo1[0]) | (tlb_rd_hi[7:0] == snap_hi_q[7:0]);
  assign match      = cmp_en_q & vpn_match & asid_match;

  // Lowest index wins: an earlier recorded hit takes precedence over this cycle's compare.
  assign probe_hit  = hit_q | match;
  assign probe_idx  = hit_q ? hit_idx_q : cmp_idx_q;
  assign probe_last = cmp_en_q & (cmp_idx_q == LAST_IDX);

`ifdef TLBSEQ_EARLY_EXIT_EN
  assign probe_exit = probe_last | match;
`else
  assign probe_exit = probe_last;
`endif

  always_comb begin
    state_d      = state_q;
    snap_op_d    = snap_op_q;
    snap_hi_d    = snap_hi_q;
    rd_idx_d     = rd_idx_q;
    cmp_idx_d    = cmp_idx_q;
    cmp_en_d     = cmp_en_q;
    hit_d        = hit_q;
    hit_idx_d    = hit_idx_q;
    we_d         = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_hi_d      = wr_hi_q;
    wr_lo0_d     = wr_lo0_q;
    wr_lo1_d     = wr_lo1_q;
    wr_mask_d    = wr_mask_q;
    tlbr_d       = 1'b0;
    tlbr_hi_d    = tlbr_hi_q;
    tlbr_lo0_d   = tlbr_lo0_q;
    tlbr_lo1_d   = tlbr_lo1_q;
    tlbr_mask_d  = tlbr_mask_q;
    tlbp_d       = 1'b0;
    tlbp_index_d = tlbp_index_q;
    tlbwr_d      = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          snap_op_d = op_type;
          snap_hi_d = cp0_entryhi;
          // The write-port registers double as the EntryLo/PageMask/Index snapshot.
          wr_hi_d   = cp0_entryhi;
          wr_lo0_d  = cp0_entrylo0;
          wr_lo1_d  = cp0_entrylo1;
          wr_mask_d = cp0_mask;
          wr_idx_d  = (op_type == OP_TLBWR) ? cp0_random[IDXBITS-1:0]
                                            : cp0_index[IDXBITS-1:0];
          unique case (op_type)
            OP_TLBP: begin
              state_d  = StProbe;
              rd_idx_d = '0;
              cmp_en_d = 1'b0;
              hit_d    = 1'b0;
            end
            OP_TLBR: begin
              state_d  = StRead;
              rd_idx_d = cp0_index[IDXBITS-1:0];
            end
            OP_TLBWI, OP_TLBWR: begin
              state_d = StWrite;
              we_d    = 1'b1;
            end
            default: state_d = StIdle;
          endcase
        end
      end

      StProbe: begin
        // Counter stops at the last entry instead of wrapping.
        if (rd_idx_q != LAST_IDX) begin
          rd_idx_d = rd_idx_q + IDXBITS'(1);
        end
        cmp_idx_d = rd_idx_q;
        cmp_en_d  = 1'b1;
        if (match && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = cmp_idx_q;
        end
        if (probe_exit) begin
          state_d      = StResp;
          tlbp_d       = 1'b1;
          done_d       = 1'b1;
          tlbp_index_d = probe_hit ? {{(32 - IDXBITS){1'b0}}, probe_idx} : PROBE_MISS;
          cmp_en_d     = 1'b0;
        end
      end

      StRead: begin
        // Index was presented on entry; data returns next cycle.
        state_d = StRead2;
      end

      StRead2: begin
        state_d     = StResp;
        tlbr_d      = 1'b1;
        done_d      = 1'b1;
        tlbr_hi_d   = tlb_rd_hi;
        tlbr_lo0_d  = tlb_rd_lo0;
        tlbr_lo1_d  = tlb_rd_lo1;
        tlbr_mask_d = tlb_rd_mask;
      end

      StWrite: begin
        state_d = StResp;
        tlbwr_d = (snap_op_q == OP_TLBWR);
        done_d  = 1'b1;
      end

      StResp: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      snap_op_q    <= 2'd0;
      snap_hi_q    <= 32'd0;
      rd_idx_q     <= '0;
      cmp_idx_q    <= '0;
      cmp_en_q     <= 1'b0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      we_q         <= 1'b0;
      wr_idx_q     <= '0;
      wr_hi_q      <= 32'd0;
      wr_lo0_q     <= 32'd0;
      wr_lo1_q     <= 32'd0;
      wr_mask_q    <= 12'd0;
      tlbr_q       <= 1'b0;
      tlbr_hi_q    <= 32'd0;
      tlbr_lo0_q   <= 32'd0;
      tlbr_lo1_q   <= 32'd0;
      tlbr_mask_q  <= 12'd0;
      tlbp_q       <= 1'b0;
      tlbp_index_q <= 32'd0;
      tlbwr_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_op_q    <= snap_op_d;
      snap_hi_q    <= snap_hi_d;
      rd_idx_q     <= rd_idx_d;
      cmp_idx_q    <= cmp_idx_d;
      cmp_en_q     <= cmp_en_d;
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      we_q         <= we_d;
      wr_idx_q     <= wr_idx_d;
      wr_hi_q      <= wr_hi_d;
      wr_lo0_q     <= wr_lo0_d;
      wr_lo1_q     <= wr_lo1_d;
      wr_mask_q    <= wr_mask_d;
      tlbr_q       <= tlbr_d;
      tlbr_hi_q    <= tlbr_hi_d;
      tlbr_lo0_q   <= tlbr_lo0_d;
      tlbr_lo1_q   <= tlbr_lo1_d;
      tlbr_mask_q  <= tlbr_mask_d;
      tlbp_q       <= tlbp_d;
      tlbp_index_q <= tlbp_index_d;
      tlbwr_q      <= tlbwr_d;
      done_q       <= done_d;
    end
  end

  assign op_ready    = (state_q == StIdle);

  assign tlb_rd_idx  = rd_idx_q;

  assign tlb_we      = we_q;
  assign tlb_wr_idx  = wr_idx_q;
  assign tlb_wr_hi   = wr_hi_q;
  assign tlb_wr_lo0  = wr_lo0_q;
  assign tlb_wr_lo1  = wr_lo1_q;
  assign tlb_wr_mask = wr_mask_q;

  assign tlbr        = tlbr_q;
  assign tlbr_hi     = tlbr_hi_q;
  assign tlbr_lo0    = tlbr_lo0_q;
  assign tlbr_lo1    = tlbr_lo1_q;
  assign tlbr_mask   = tlbr_mask_q;

  assign tlbp        = tlbp_q;
  assign tlbp_index  = tlbp_index_q;

  assign tlbwr       = tlbwr_q;
  assign done        = done_q;

  // Index/Random bits above the entry range and EntryHi[12:8] play no part in any operation.
  logic unused_bits;
  assign unused_bits = ^{cp0_index[31:IDXBITS], cp0_random[31:IDXBITS], snap_hi_q[12:8]};

endmodule

// File: tb/tb_tlb_seq.sv
// tb_tlb_seq: randomized self-checking bench for tlb_seq with a synchronous-read TLB model and
// a behavioural probe/read/write reference computed from the architectural rules.
module tb_tlb_seq;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_type = 2'd0;
  logic [31:0] cp0_index = 32'd0, cp0_random = 32'd0, cp0_entryhi = 32'd0;
  logic [31:0] cp0_entrylo0 = 32'd0, cp0_entrylo1 = 32'd0;
  logic [11:0] cp0_mask = 12'd0;
  logic [3:0]  tlb_rd_idx;
  logic [31:0] rd_hi, rd_lo0, rd_lo1;
  logic [11:0] rd_mask;
  logic        tlb_we;
  logic [3:0]  tlb_wr_idx;
  logic [31:0] tlb_wr_hi, tlb_wr_lo0, tlb_wr_lo1;
  logic [11:0] tlb_wr_mask;
  logic        tlbr, tlbp, tlbwr, done;
  logic [31:0] tlbr_hi, tlbr_lo0, tlbr_lo1, tlbp_index;
  logic [11:0] tlbr_mask;

  logic [31:0] mem_hi [N];
  logic [31:0] mem_lo0[N];
  logic [31:0] mem_lo1[N];
  logic [11:0] mem_mask[N];

  int n_cmp = 0;
  int n_fail = 0;

  // Observations of one operation (cycle numbers count from 1 = first cycle after accept)
  int          o_done_cyc, o_done_cnt, o_tlbp_cyc, o_tlbp_cnt, o_tlbr_cyc, o_tlbr_cnt;
  int          o_tlbwr_cyc, o_tlbwr_cnt, o_we_cyc, o_we_cnt, o_ready_busy, o_extra;
  logic        o_ready_issue, o_ready_after;
  logic [3:0]  o_wr_idx;
  logic [31:0] o_wr_hi, o_wr_lo0, o_wr_lo1, o_tlbp_index, o_tlbp_index_after;
  logic [11:0] o_wr_mask, o_tlbr_mask;
  logic [31:0] o_tlbr_hi, o_tlbr_lo0, o_tlbr_lo1;

  always #5 clk = ~clk;

  // Synchronous-read TLB array
  always @(posedge clk) begin
    rd_hi   <= mem_hi[tlb_rd_idx];
    rd_lo0  <= mem_lo0[tlb_rd_idx];
    rd_lo1  <= mem_lo1[tlb_rd_idx];
    rd_mask <= mem_mask[tlb_rd_idx];
  end

  tlb_seq #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .cp0_index(cp0_index), .cp0_random(cp0_random), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_mask(cp0_mask),
    .tlb_rd_idx(tlb_rd_idx), .tlb_rd_hi(rd_hi), .tlb_rd_lo0(rd_lo0), .tlb_rd_lo1(rd_lo1),
    .tlb_rd_mask(rd_mask),
    .tlb_we(tlb_we), .tlb_wr_idx(tlb_wr_idx), .tlb_wr_hi(tlb_wr_hi), .tlb_wr_lo0(tlb_wr_lo0),
    .tlb_wr_lo1(tlb_wr_lo1), .tlb_wr_mask(tlb_wr_mask),
    .tlbr(tlbr), .tlbr_hi(tlbr_hi), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1),
    .tlbr_mask(tlbr_mask),
    .tlbp(tlbp), .tlbp_index(tlbp_index), .tlbwr(tlbwr), .done(done)
  );

  // Reference: lowest entry whose unmasked VPN2 bits agree and whose ASID agrees or is global.
  function automatic int model_probe(input logic [31:0] hi);
    for (int i = 0; i < N; i++) begin
      bit vpn_ok;
      bit asid_ok;
      vpn_ok = 1'b1;
      for (int b = 13; b < 32; b++) begin
        bit ignored;
        ignored = 1'b0;
        if (b - 13 < 12) ignored = mem_mask[i][b - 13];
        if (!ignored && (mem_hi[i][b] != hi[b])) vpn_ok = 1'b0;
      end
      asid_ok = (mem_lo0[i][0] && mem_lo1[i][0]) || (mem_hi[i][7:0] == hi[7:0]);
      if (vpn_ok && asid_ok) return i;
    end
    return -1;
  endfunction

  function automatic int probe_lat(input int hit);
`ifdef TLBSEQ_EARLY_EXIT_EN
    if (hit >= 0) return hit + 3;
`endif
    return N + 2;
  endfunction

  function automatic logic [31:0] probe_val(input int hit);
    return (hit >= 0) ? 32'(hit) : 32'h8000_0000;
  endfunction

  // Entries that can never match a probe with EntryHi[31:29] == 0.
  task automatic fill_nomatch();
    for (int i = 0; i < N; i++) begin
      mem_hi[i]   = {3'b111, 12'h000, 4'(i), 5'd0, 8'hEE};
      mem_lo0[i]  = $urandom & 32'hFFFF_FFFE;
      mem_lo1[i]  = $urandom;
      mem_mask[i] = 12'h000;
    end
  endtask

  // Drive one request (caller is just after a falling edge) and watch until one cycle past done.
  task automatic issue(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] rnd,
                       input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1,
                       input logic [11:0] mask);
    o_ready_issue = op_ready;
    op_valid = 1'b1; op_type = op; cp0_index = idx; cp0_random = rnd;
    cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; cp0_mask = mask;
    @(posedge clk);
    #1;
    // Scramble CP0 after accept; the operation must use the captured values.
    op_valid = 1'b0; op_type = 2'($urandom); cp0_index = $urandom; cp0_random = $urandom;
    cp0_entryhi = $urandom; cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom;
    cp0_mask = 12'($urandom);
    o_done_cyc = -1; o_done_cnt = 0; o_tlbp_cyc = -1; o_tlbp_cnt = 0; o_tlbr_cyc = -1;
    o_tlbr_cnt = 0; o_tlbwr_cyc = -1; o_tlbwr_cnt = 0; o_we_cyc = -1; o_we_cnt = 0;
    o_ready_busy = 0; o_extra = 0; o_ready_after = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (o_done_cyc >= 0) begin
        o_ready_after = op_ready;
        o_tlbp_index_after = tlbp_index;
        if (tlbp || tlbr || tlbwr || done || tlb_we) o_extra++;
        break;
      end
      if (op_ready) o_ready_busy++;
      if (tlb_we) begin
        if (o_we_cnt == 0) begin
          o_we_cyc = c; o_wr_idx = tlb_wr_idx; o_wr_hi = tlb_wr_hi; o_wr_lo0 = tlb_wr_lo0;
          o_wr_lo1 = tlb_wr_lo1; o_wr_mask = tlb_wr_mask;
        end
        o_we_cnt++;
      end
      if (tlbp) begin
        if (o_tlbp_cnt == 0) begin o_tlbp_cyc = c; o_tlbp_index = tlbp_index; end
        o_tlbp_cnt++;
      end
      if (tlbr) begin
        if (o_tlbr_cnt == 0) begin
          o_tlbr_cyc = c; o_tlbr_hi = tlbr_hi; o_tlbr_lo0 = tlbr_lo0; o_tlbr_lo1 = tlbr_lo1;
          o_tlbr_mask = tlbr_mask;
        end
        o_tlbr_cnt++;
      end
      if (tlbwr) begin
        if (o_tlbwr_cnt == 0) o_tlbwr_cyc = c;
        o_tlbwr_cnt++;
      end
      if (done) begin o_done_cyc = c; o_done_cnt++; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({op_ready, done, tlb_we, tlbp, tlbr, tlbwr} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 100000", {op_ready, done, tlb_we, tlbp, tlbr, tlbwr});
    end
    n_cmp++;
    if ({tlb_rd_idx, tlb_wr_idx, tlbp_index} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_idx: got rd=%0h wr=%0h pidx=%0h want 0", tlb_rd_idx, tlb_wr_idx,
               tlbp_index);
    end
    n_cmp++;
    if ({tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask, tlb_wr_hi, tlb_wr_lo0, tlb_wr_lo1, tlb_wr_mask}
        !== 216'd0) begin
      n_fail++;
      $display("FAIL reset_data: got nonzero tlbr_*/tlb_wr_* want 0");
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", op_ready);
    end
  endtask

  task automatic test_tlbr_directed();
    fill_nomatch();
    mem_hi[5] = 32'h0040_2011; mem_lo0[5] = 32'h0000_1017; mem_lo1[5] = 32'h0000_1057;
    mem_mask[5] = 12'h000;
    issue(2'd1, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 12'd0);
    n_cmp++;
    if (o_tlbr_cyc !== 3 || o_done_cyc !== 3 || o_tlbr_cnt !== 1 || o_done_cnt !== 1) begin
      n_fail++;
      $display("FAIL tlbr_timing: got tlbr@%0d x%0d done@%0d x%0d want 3 x1 3 x1", o_tlbr_cyc,
               o_tlbr_cnt, o_done_cyc, o_done_cnt);
    end
    n_cmp++;
    if ({o_tlbr_hi, o_tlbr_lo0, o_tlbr_lo1, o_tlbr_mask} !==
        {32'h0040_2011, 32'h0000_1017, 32'h0000_1057, 12'h000}) begin
      n_fail++;
      $display("FAIL tlbr_data: got %h %h %h %h want 00402011 00001017 00001057 000", o_tlbr_hi,
               o_tlbr_lo0, o_tlbr_lo1, o_tlbr_mask);
    end
    n_cmp++;
    if (o_ready_busy !== 0 || o_ready_after !== 1'b1 || o_ready_issue !== 1'b1) begin
      n_fail++;
      $display("FAIL tlbr_ready: got busy=%0d after=%b issue=%b want 0 1 1", o_ready_busy,
               o_ready_after, o_ready_issue);
    end
  endtask

  task automatic test_tlbp_two_hits();
    fill_nomatch();
    mem_hi[3] = 32'h0040_2011; mem_hi[9] = 32'h0040_2011;
    issue(2'd0, 32'd0, 32'd0, 32'h0040_2011, 32'd0, 32'd0, 12'd0);
    n_cmp++;
    if (o_tlbp_index !== 32'd3) begin
      n_fail++;
      $display("FAIL tlbp_lowest: got %h want 00000003", o_tlbp_index);
    end
    n_cmp++;
    if (o_tlbp_cyc !== probe_lat(3) || o_done_cyc !== probe_lat(3) || o_tlbp_cnt !== 1) begin
      n_fail++;
      $display("FAIL tlbp_hit_lat: got tlbp@%0d x%0d done@%0d want %0d", o_tlbp_cyc, o_tlbp_cnt,
               o_done_cyc, probe_lat(3));
    end
    n_cmp++;
    if (o_tlbp_index_after !== 32'd3 || o_extra !== 0) begin
      n_fail++;
      $display("FAIL tlbp_hold: got %h extra=%0d want 00000003 0", o_tlbp_index_after, o_extra);
    end
  endtask

  task automatic test_tlbp_miss();
    fill_nomatch();
    issue(2'd0, 32'd0, 32'd0, 32'h0040_2011, 32'd0, 32'd0, 12'd0);
    n_cmp++;
    if (o_tlbp_index !== 32'h8000_0000 || o_tlbp_cyc !== N + 2 || o_done_cyc !== N + 2) begin
      n_fail++;
      $display("FAIL tlbp_miss: got %h @%0d done@%0d want 80000000 @%0d", o_tlbp_index,
               o_tlbp_cyc, o_done_cyc, N + 2);
    end
  endtask

  task automatic test_asid_global();
    fill_nomatch();
    mem_hi[4] = 32'h0040_2022; mem_lo0[4] = 32'h1; mem_lo1[4] = 32'h1;
    issue(2'd0, 32'd0, 32'd0, 32'h0040_2011, 32'd0, 32'd0, 12'd0);
    n_cmp++;
    if (o_tlbp_index !== 32'd4 || o_tlbp_cyc !== probe_lat(4)) begin
      n_fail++;
      $display("FAIL asid_global_hit: got %h @%0d want 00000004 @%0d", o_tlbp_index, o_tlbp_cyc,
               probe_lat(4));
    end
    mem_lo1[4] = 32'h0;
    issue(2'd0, 32'd0, 32'd0, 32'h0040_2011, 32'd0, 32'd0, 12'd0);
    n_cmp++;
    if (o_tlbp_index !== 32'h8000_0000 || o_tlbp_cyc !== N + 2) begin
      n_fail++;
      $display("FAIL asid_half_global: got %h @%0d want 80000000 @%0d", o_tlbp_index,
               o_tlbp_cyc, N + 2);
    end
    // Mask 0xFFF: VPN2 bits 24:13 differ but are ignored.
    mem_hi[4] = 32'h0040_2022 ^ 32'h01FF_E000; mem_lo1[4] = 32'h1; mem_mask[4] = 12'hFFF;
    issue(2'd0, 32'd0, 32'd0, 32'h0040_2011, 32'd0, 32'd0, 12'd0);
    n_cmp++;
    if (o_tlbp_index !== 32'd4 || o_tlbp_cyc !== probe_lat(4)) begin
      n_fail++;
      $display("FAIL mask_ignore: got %h @%0d want 00000004 @%0d", o_tlbp_index, o_tlbp_cyc,
               probe_lat(4));
    end
  endtask

  task automatic test_write();
    issue(2'd3, 32'd3, 32'd9, 32'hDEAD_B0EF, 32'h1234_5671, 32'h7654_3211, 12'hA5C);
    n_cmp++;
    if (o_we_cyc !== 1 || o_we_cnt !== 1 || o_wr_idx !== 4'd9) begin
      n_fail++;
      $display("FAIL tlbwr_we: got we@%0d x%0d idx=%0d want 1 x1 9", o_we_cyc, o_we_cnt,
               o_wr_idx);
    end
    n_cmp++;
    if ({o_wr_hi, o_wr_lo0, o_wr_lo1, o_wr_mask} !==
        {32'hDEAD_B0EF, 32'h1234_5671, 32'h7654_3211, 12'hA5C}) begin
      n_fail++;
      $display("FAIL tlbwr_data: got %h %h %h %h", o_wr_hi, o_wr_lo0, o_wr_lo1, o_wr_mask);
    end
    n_cmp++;
    if (o_tlbwr_cyc !== 2 || o_tlbwr_cnt !== 1 || o_done_cyc !== 2 || o_done_cnt !== 1) begin
      n_fail++;
      $display("FAIL tlbwr_pulse: got tlbwr@%0d x%0d done@%0d x%0d want 2 x1 2 x1", o_tlbwr_cyc,
               o_tlbwr_cnt, o_done_cyc, o_done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'd2, 32'h0000_0016, 32'd1, 32'h1111_2222, 32'h3, 32'h5, 12'h00F);
    issue(2'd2, 32'h0000_002B, 32'd1, 32'h3333_4444, 32'h7, 32'h9, 12'h0F0);
    n_cmp++;
    if (o_ready_issue !== 1'b1 || o_we_cyc !== 1 || o_wr_idx !== 4'hB || o_tlbwr_cnt !== 0 ||
        o_wr_hi !== 32'h3333_4444 || o_done_cyc !== 2) begin
      n_fail++;
      $display("FAIL back_to_back: got rdy=%b we@%0d idx=%h tlbwr=%0d hi=%h done@%0d",
               o_ready_issue, o_we_cyc, o_wr_idx, o_tlbwr_cnt, o_wr_hi, o_done_cyc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [1:0]  op;
      logic [31:0] hi, idx, rnd, lo0, lo1;
      logic [11:0] mask;
      int          e;
      for (int i = 0; i < N; i++) begin
        mem_hi[i]   = ($urandom & 32'h0000_7F00) | 32'($urandom_range(0, 3));
        mem_lo0[i]  = $urandom;
        mem_lo1[i]  = $urandom;
        mem_mask[i] = ($urandom_range(0, 3) == 0) ? 12'h003 : 12'h000;
      end
      op   = 2'($urandom);
      hi   = ($urandom & 32'h0000_7F00) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) hi = hi | 32'h8000_0000;
      idx  = $urandom; rnd = $urandom; lo0 = $urandom; lo1 = $urandom; mask = 12'($urandom);
      issue(op, idx, rnd, hi, lo0, lo1, mask);
      n_cmp++;
      if (o_ready_after !== 1'b1 || o_extra !== 0 || o_done_cnt !== 1) begin
        n_fail++;
        $display("FAIL rnd_end it%0d: got ready=%b extra=%0d done x%0d want 1 0 1", it,
                 o_ready_after, o_extra, o_done_cnt);
      end
      if (op == 2'd0) begin
        e = model_probe(hi);
        n_cmp++;
        if (o_tlbp_index !== probe_val(e) || o_tlbp_cyc !== probe_lat(e) ||
            o_done_cyc !== probe_lat(e)) begin
          n_fail++;
          $display("FAIL rnd_tlbp it%0d: got %h @%0d want %h @%0d", it, o_tlbp_index,
                   o_tlbp_cyc, probe_val(e), probe_lat(e));
        end
      end else if (op == 2'd1) begin
        e = int'(idx % N);
        n_cmp++;
        if (o_tlbr_cyc !== 3 || {o_tlbr_hi, o_tlbr_lo0, o_tlbr_lo1, o_tlbr_mask} !==
            {mem_hi[e], mem_lo0[e], mem_lo1[e], mem_mask[e]}) begin
          n_fail++;
          $display("FAIL rnd_tlbr it%0d: got @%0d %h %h want @3 entry %0d %h %h", it,
                   o_tlbr_cyc, o_tlbr_hi, o_tlbr_lo0, e, mem_hi[e], mem_lo0[e]);
        end
      end else begin
        e = (op == 2'd3) ? int'(rnd % N) : int'(idx % N);
        n_cmp++;
        if (o_we_cyc !== 1 || o_we_cnt !== 1 || o_wr_idx !== 4'(e) ||
            {o_wr_hi, o_wr_lo0, o_wr_lo1, o_wr_mask} !== {hi, lo0, lo1, mask} ||
            o_tlbwr_cnt !== ((op == 2'd3) ? 1 : 0) || o_done_cyc !== 2) begin
          n_fail++;
          $display("FAIL rnd_write it%0d op%0d: got we@%0d x%0d idx=%0d tlbwr=%0d done@%0d want idx=%0d",
                   it, op, o_we_cyc, o_we_cnt, o_wr_idx, o_tlbwr_cnt, o_done_cyc, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_probe();
    int found;
    int bad;
    fill_nomatch();
    op_valid = 1'b1; op_type = 2'd0; cp0_entryhi = 32'h0040_2011;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      @(negedge clk);
      if (tlb_rd_idx == 4'd7) found = 1;
    end
    n_cmp++;
    if (found !== 1) begin
      n_fail++;
      $display("FAIL midprobe_reach: got scan index 7 seen=%0d want 1", found);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({op_ready, tlbp, done, tlb_we} !== 4'b1000 || tlb_rd_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL midprobe_abort: got rdy/tlbp/done/we=%b rd_idx=%0d want 1000 0",
               {op_ready, tlbp, done, tlb_we}, tlb_rd_idx);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (tlbp || done || tlb_we || tlbr || tlbwr || !op_ready) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midprobe_quiet: got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    fill_nomatch();
    test_reset();
    test_tlbr_directed();
    test_tlbp_two_hits();
    test_tlbp_miss();
    test_asid_global();
    test_write();
    test_back_to_back();
    test_random();
    test_reset_mid_probe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
